// File: rtl/code_conv_pkg.sv
// ---------------------------------------------------------------------------
// code_conv_pkg
// Shared definitions for the code converter / accumulator slice.
//   - default parameter values used by code_conv_accum
//   - conversion mode encoding (sampled with each accepted code)
//   - saturation limits for the default accumulator width
// ---------------------------------------------------------------------------
package code_conv_pkg;

   localparam int unsigned DEF_W     = 4;
   localparam int unsigned DEF_ACC_W = 8;
   localparam int unsigned DEF_STEP  = 1;
   localparam int unsigned DEF_SAT   = 0;
   localparam int unsigned DEF_ERR_W = 8;

   // Clamp limits of the default-width accumulator when saturating.
   localparam int unsigned DEF_ACC_MIN = 0;
   localparam int unsigned DEF_ACC_MAX = (2 ** DEF_ACC_W) - 1;

   typedef enum logic {
      MODE_B2G = 1'b0,   // binary -> Gray
      MODE_G2B = 1'b1    // Gray -> binary
   } mode_e;

endpackage

// File: rtl/code_conv_core.sv
// ---------------------------------------------------------------------------
// code_conv_core
// Purely combinational code converter with range checks.
// Ports:
//   A       in  W   input code
//   mode    in  1   0 = binary->Gray, 1 = Gray->binary
//   conv    out W   converted code
//   in_err  out 1   A is above CODE_MAX
//   out_err out 1   conv is above OUT_MAX
// ---------------------------------------------------------------------------
module code_conv_core
   import code_conv_pkg::*;
#(
   parameter int unsigned W        = DEF_W,
   parameter int unsigned CODE_MAX = (2 ** W) - 1,
   parameter int unsigned OUT_MAX  = (2 ** W) - 1
) (
   input  logic [W-1:0] A,
   input  logic         mode,
   output logic [W-1:0] conv,
   output logic         in_err,
   output logic         out_err
);

   localparam logic [31:0] CODE_MAX_V = CODE_MAX;
   localparam logic [31:0] OUT_MAX_V  = OUT_MAX;

   logic [W-1:0] gray;
   logic [W-1:0] bin;

   assign gray = A ^ (A >> 1);

   // Gray->binary: bit i is the XOR of all input bits at or above i.
   // Computed per bit as a reduction so there is no bit-to-bit feedback.
   always_comb begin
      bin = '0;
      for (int i = 0; i < int'(W); i++) begin
         bin[i] = ^(A >> i);
      end
   end

   assign conv    = (mode == MODE_G2B) ? bin : gray;
   assign in_err  = 32'(A)    > CODE_MAX_V;
   assign out_err = 32'(conv) > OUT_MAX_V;

endmodule

// File: rtl/code_conv_accum.sv
// ---------------------------------------------------------------------------
// code_conv_accum
// Converts each accepted code (binary<->Gray), range-checks it, registers
// the result in a single output stage and steps an up/down accumulator.
// Ports:
//   clk        in   1      system clock (rising edge)
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous clear of sum, err_cnt, acc_ovf
//   mode       in   1      0 = binary->Gray, 1 = Gray->binary
//   in_valid   in   1      A is presented
//   in_ready   out  1      block can accept A this cycle
//   A          in   W      input code
//   out_valid  out  1      B/incorrect hold a result
//   out_ready  in   1      downstream consumes the result
//   B          out  W      converted code (registered)
//   incorrect  out  1      input or output range error for the result in B
//   sum        out  ACC_W  accumulator
//   err_cnt    out  ERR_W  saturating count of incorrect results
//   acc_ovf    out  1      one-cycle pulse: accumulator wrapped or clamped
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Input side: accept = in_valid && in_ready, in_ready = !out_valid ||
// out_ready, so a held result frees its slot in the same cycle it is
// consumed. Output side: while out_valid && !out_ready, B, incorrect and
// out_valid do not change; out_valid drops after consumption unless a new
// code is accepted on that same edge.
// ---------------------------------------------------------------------------
module code_conv_accum
   import code_conv_pkg::*;
#(
   parameter int unsigned W        = DEF_W,
   parameter int unsigned CODE_MAX = (2 ** W) - 1,
   parameter int unsigned OUT_MAX  = (2 ** W) - 1,
   parameter int unsigned ACC_W    = DEF_ACC_W,
   parameter int unsigned STEP     = DEF_STEP,
   parameter int unsigned SAT      = DEF_SAT,
   parameter int unsigned ERR_W    = DEF_ERR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     A,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     B,
   output logic             incorrect,
   output logic [ACC_W-1:0] sum,
   output logic [ERR_W-1:0] err_cnt,
   output logic             acc_ovf
);

   localparam logic [ACC_W:0]   STEP_V  = (ACC_W + 1)'(STEP);
   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

   logic [W-1:0]     conv;
   logic             in_err;
   logic             out_err;
   logic             bad;
   logic             accept;
   logic             step_en;
   logic [ACC_W:0]   sum_ext;
   logic [ACC_W:0]   raw;
   logic [ACC_W-1:0] sum_nxt;
   logic             ovf_evt;

   code_conv_core #(
      .W        (W),
      .CODE_MAX (CODE_MAX),
      .OUT_MAX  (OUT_MAX)
   ) u_core (
      .A       (A),
      .mode    (mode),
      .conv    (conv),
      .in_err  (in_err),
      .out_err (out_err)
   );

   assign bad      = in_err | out_err;
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign step_en  = accept && !bad && (conv != '0);

   // One extra bit above the accumulator catches carry (up) and borrow
   // (down). Odd results count down, even nonzero results count up.
   always_comb begin
      sum_ext = {1'b0, sum};
      if (conv[0]) begin
         raw = sum_ext - STEP_V;
      end else begin
         raw = sum_ext + STEP_V;
      end
      ovf_evt = raw[ACC_W];
      if ((SAT != 0) && ovf_evt) begin
         sum_nxt = conv[0] ? '0 : '1;
      end else begin
         sum_nxt = raw[ACC_W-1:0];
      end
   end

   // Output register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         B         <= '0;
         incorrect <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         B         <= conv;
         incorrect <= bad;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Accumulator and error counter; clear wins over a same-cycle accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum     <= '0;
         err_cnt <= '0;
         acc_ovf <= 1'b0;
      end else if (clear) begin
         sum     <= '0;
         err_cnt <= '0;
         acc_ovf <= 1'b0;
      end else begin
         acc_ovf <= 1'b0;
         if (step_en) begin
            sum     <= sum_nxt;
            acc_ovf <= ovf_evt;
         end
         if (accept && bad && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_code_conv_accum.sv
// ---------------------------------------------------------------------------
// tb_code_conv_accum
// Two instances share all inputs: dut_d uses default parameters, dut_s uses
// CODE_MAX=12, OUT_MAX=6, SAT=1. Both are checked every cycle against a
// behavioural model; table rows and hand sequences add fixed expectations.
// ---------------------------------------------------------------------------
module tb_code_conv_accum;

   localparam int W      = 4;
   localparam int ACC_W  = 8;
   localparam int ERR_W  = 8;
   localparam int STEP   = 1;
   localparam int ACC_MX = (2 ** ACC_W) - 1;
   localparam int ERR_MX = (2 ** ERR_W) - 1;

   // ---------------- clock / reset / signals ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic mode = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [W-1:0] A = '0;

   logic             in_ready_d, out_valid_d, incorrect_d, acc_ovf_d;
   logic [W-1:0]     B_d;
   logic [ACC_W-1:0] sum_d;
   logic [ERR_W-1:0] err_d;
   logic             in_ready_s, out_valid_s, incorrect_s, acc_ovf_s;
   logic [W-1:0]     B_s;
   logic [ACC_W-1:0] sum_s;
   logic [ERR_W-1:0] err_s;

   always #5 clk = ~clk;

   code_conv_accum dut_d (
      .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready_d), .A(A),
      .out_valid(out_valid_d), .out_ready(out_ready), .B(B_d),
      .incorrect(incorrect_d), .sum(sum_d), .err_cnt(err_d),
      .acc_ovf(acc_ovf_d)
   );

   code_conv_accum #(.CODE_MAX(12), .OUT_MAX(6), .SAT(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready_s), .A(A),
      .out_valid(out_valid_s), .out_ready(out_ready), .B(B_s),
      .incorrect(incorrect_s), .sum(sum_s), .err_cnt(err_s),
      .acc_ovf(acc_ovf_s)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int cm[2]  = '{15, 12};
   int om[2]  = '{15, 6};
   int sat[2] = '{0, 1};

   bit m_valid;
   int m_b[2], m_inc[2], m_sum[2], m_err[2], m_ovf[2];

   function automatic int to_gray(input int a);
      return a ^ (a >> 1);
   endfunction

   function automatic int from_gray(input int g);
      int b = g;
      for (int s = g >> 1; s != 0; s = s >> 1) b = b ^ s;
      return b;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      for (int k = 0; k < 2; k++) begin
         m_b[k] = 0; m_inc[k] = 0; m_sum[k] = 0; m_err[k] = 0; m_ovf[k] = 0;
      end
   endtask

   task automatic model_step();
      bit acc;
      int a, conv, nv;
      bit bad;
      acc = in_valid && (!m_valid || out_ready);
      a = int'(A);
      for (int k = 0; k < 2; k++) begin
         conv = mode ? from_gray(a) : to_gray(a);
         bad  = (a > cm[k]) || (conv > om[k]);
         if (acc) begin
            m_b[k] = conv;
            m_inc[k] = int'(bad);
         end
         m_ovf[k] = 0;
         if (clear) begin
            m_sum[k] = 0;
            m_err[k] = 0;
         end else if (acc) begin
            if (bad) begin
               if (m_err[k] < ERR_MX) m_err[k]++;
            end else if (conv != 0) begin
               nv = (conv % 2 == 1) ? m_sum[k] - STEP : m_sum[k] + STEP;
               if (nv < 0 || nv > ACC_MX) begin
                  m_ovf[k] = 1;
                  if (sat[k] != 0) nv = (nv < 0) ? 0 : ACC_MX;
                  else nv = (nv + ACC_MX + 1) % (ACC_MX + 1);
               end
               m_sum[k] = nv;
            end
         end
      end
      if (acc) m_valid = 1;
      else if (out_ready) m_valid = 0;
   endtask

   task automatic check_out(input string tag);
      check({tag, ".d.in_ready"},  in_ready_d,  !m_valid || out_ready);
      check({tag, ".d.out_valid"}, out_valid_d, m_valid);
      check({tag, ".d.B"},         B_d,         m_b[0]);
      check({tag, ".d.incorrect"}, incorrect_d, m_inc[0]);
      check({tag, ".d.sum"},       sum_d,       m_sum[0]);
      check({tag, ".d.err_cnt"},   err_d,       m_err[0]);
      check({tag, ".d.acc_ovf"},   acc_ovf_d,   m_ovf[0]);
      check({tag, ".s.in_ready"},  in_ready_s,  !m_valid || out_ready);
      check({tag, ".s.out_valid"}, out_valid_s, m_valid);
      check({tag, ".s.B"},         B_s,         m_b[1]);
      check({tag, ".s.incorrect"}, incorrect_s, m_inc[1]);
      check({tag, ".s.sum"},       sum_s,       m_sum[1]);
      check({tag, ".s.err_cnt"},   err_s,       m_err[1]);
      check({tag, ".s.acc_ovf"},   acc_ovf_s,   m_ovf[1]);
   endtask

   // ---------------- driver tasks (called at a falling edge) ----------------
   task automatic drive(input string tag, input bit v, input int a,
                        input bit md, input bit ordy, input bit clr);
      in_valid = v; A = W'(a); mode = md; out_ready = ordy; clear = clr;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_out(tag);
   endtask

   task automatic do_reset();
      in_valid = 0; clear = 0; out_ready = 1; mode = 0; A = '0;
      rst_n = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      check_out("reset");
   endtask

   // ---------------- table ----------------
   typedef struct {
      int a; bit md;
      int eb; bit einc; int esum; bit eovf;
   } vec_t;

   vec_t tbl[7];

   initial begin
      // Default instance, stream then mode change.
      tbl[0] = '{a:5, md:0, eb:7, einc:0, esum:255, eovf:1};
      tbl[1] = '{a:6, md:0, eb:5, einc:0, esum:254, eovf:0};
      tbl[2] = '{a:3, md:0, eb:2, einc:0, esum:255, eovf:0};
      tbl[3] = '{a:0, md:0, eb:0, einc:0, esum:255, eovf:0};
      tbl[4] = '{a:7, md:1, eb:5, einc:0, esum:254, eovf:0};
      tbl[5] = '{a:4, md:1, eb:7, einc:0, esum:253, eovf:0};
      tbl[6] = '{a:6, md:1, eb:4, einc:0, esum:254, eovf:0};

      @(negedge clk);
      do_reset();

      for (int i = 0; i < 7; i++) begin
         drive("tbl", 1, tbl[i].a, tbl[i].md, 1, 0);
         check($sformatf("tbl%0d.B", i),       B_d,         tbl[i].eb);
         check($sformatf("tbl%0d.inc", i),     incorrect_d, tbl[i].einc);
         check($sformatf("tbl%0d.sum", i),     sum_d,       tbl[i].esum);
         check($sformatf("tbl%0d.ovf", i),     acc_ovf_d,   tbl[i].eovf);
         check($sformatf("tbl%0d.valid", i),   out_valid_d, 1);
      end
      drive("drain", 0, 0, 0, 1, 0);
      check("drain.valid", out_valid_d, 0);
      check("drain.B_hold", B_d, 4);

      // Range errors on the restricted instance.
      do_reset();
      drive("rng", 1, 13, 0, 1, 0);
      check("rng13.B", B_s, 11);
      check("rng13.inc", incorrect_s, 1);
      check("rng13.err", err_s, 1);
      check("rng13.sum", sum_s, 0);
      drive("rng", 1, 5, 0, 1, 0);
      check("rng5.B", B_s, 7);
      check("rng5.inc", incorrect_s, 1);
      check("rng5.err", err_s, 2);

      // Saturation: clamp at 0, then climb to the top and clamp there.
      do_reset();
      drive("sat", 1, 6, 0, 1, 0);
      check("sat_lo.sum", sum_s, 0);
      check("sat_lo.ovf", acc_ovf_s, 1);
      drive("sat", 1, 0, 0, 1, 0);
      check("sat_lo.pulse", acc_ovf_s, 0);
      for (int i = 0; i < 256; i++) drive("sat_up", 1, 3, 0, 1, 0);
      check("sat_hi.sum", sum_s, 255);
      check("sat_hi.ovf", acc_ovf_s, 1);

      // Backpressure: one accept, then held for four cycles.
      do_reset();
      drive("bp", 1, 3, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive("bp_hold", 1, 6, 1, 0, 0);
         check("bp_hold.B", B_d, 2);
         check("bp_hold.ready", in_ready_d, 0);
         check("bp_hold.sum", sum_d, 1);
      end
      drive("bp_go", 1, 6, 0, 1, 0);
      check("bp_go.B", B_d, 5);
      drive("bp_go", 1, 5, 0, 1, 0);
      check("bp_go2.B", B_d, 7);

      // Clear alongside an accept, then asynchronous reset mid-transfer.
      drive("clr_pre", 1, 13, 0, 1, 0);
      drive("clr", 1, 3, 0, 1, 1);
      check("clr.sum", sum_d, 0);
      check("clr.err_s", err_s, 0);
      check("clr.B", B_d, 2);
      drive("pend", 1, 5, 0, 0, 0);
      #2 rst_n = 0;
      #1;
      check("arst.valid_d", out_valid_d, 0);
      check("arst.B_d", B_d, 0);
      check("arst.sum_d", sum_d, 0);
      check("arst.err_s", err_s, 0);
      check("arst.B_s", B_s, 0);
      model_reset();
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      rst_n = 1;
      check_out("arst_rel");
      drive("post_rst", 1, 5, 0, 1, 0);
      check("post_rst.B", B_d, 7);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 15),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
